pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the RISC-V pipeline; generalises the fixed inter-stage registers (F/D, D/E, E/M, M/W).
- Carries one valid bit plus a WIDTH-bit payload and adds a ready/valid handshake, flush (bubble insertion) and global halt.
- Optional 2-entry skid mode gives a registered in_ready, so back-pressure does not form a combinational path across stages.
- Instantiated between any two stages; the payload is a packed struct flattened to WIDTH bits.

Parameters:
- WIDTH, 37, payload bits (e.g. {rd, reg_d} = 5+32).
- SKID, 0, 0 = single-entry register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- halted  input  1  global freeze; no state change while high (flush excepted).
- flush  input  1  kill all held entries and the incoming beat.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload.
- count  output  2  entries held (0..1 if SKID=0, 0..2 if SKID=1).

Behaviour:
- Reset (reset low, asynchronous): all valid bits cleared → out_valid=0, count=0; in_ready=1 (SKID=0) or 1 (SKID=1). Payload flops are not reset; out_data is don't-care while out_valid=0.
- Transfers: in beat when in_valid & in_ready; out beat when out_valid & out_ready. Both sides may transfer in the same cycle.
- halted=1:
  - in_ready=0 and out_valid=0 (gated, so no handshake completes).
  - All state holds.
  - On deassertion, out_valid returns to the held value with out_data unchanged.
- flush=1, priority over halted and over any transfer that cycle:
  - Next edge clears all valid bits (count=0). The in beat is discarded.
  - in_ready and out_valid still show their normal values that cycle, but neither side's state updates from them.
- SKID=0:
  - Single entry (v, d).
  - in_ready = ~halted & (~v | out_ready), a combinational path from out_ready.
  - Latency 1: a beat accepted at edge N appears on out_valid after edge N.
  - Full throughput when out_ready=1.
  - On an in beat: v←1 and d←in_data. Otherwise, on an out beat: v←0.
- SKID=1:
  - Main entry (v0, d0) drives out_*.
  - Skid entry (v1, d1) is filled only when the main entry is held (out_valid & ~out_ready) and an in beat arrives.
  - in_ready = ~halted & ~v1, registered from state; no combinational path from out_ready.
  - Out beat with v1=1: d0←d1, v1←0, and v0 stays 1.
  - Out beat with v1=0 and an in beat: d0←in_data.
  - in_ready deasserts only when count=2. Latency 1, full throughput.
  - Order is preserved: the skid entry always drains before newer data.
  - Simultaneous in and out beats at count=2 cannot occur (in_ready=0).
- Overflow is impossible by construction; an assertion flags in_valid & in_ready with count at maximum.
- Simulation assertions: out_data stable while out_valid & ~out_ready & ~halted & ~flush; count never exceeds 1+SKID.
- Reset mid-operation: every entry is dropped immediately, with no partial beat.

Decomposition:
- Package pipe_pkg: per-stage payload structs (fd_t, de_t, em_t, mw_t) and localparam widths via $bits, so instantiations use WIDTH=$bits(mw_t).
- Valid bits use the existing enable-flop-with-reset cell, wired with active-low async reset; payload uses the non-reset enable flop (flope).
- Sub-module pipe_skid holds the SKID=1 two-entry datapath and control; the top selects it vs the single-entry path with a generate on SKID.

Test Plan:
- Reset: reset=0 with in_valid=1 → out_valid=0, count=0. After release, send in_data=0x0A5A5A5A5 (WIDTH=37) → out_valid=1 and out_data=0x0A5A5A5A5 one cycle later.
- Streaming, both SKID values: 8 beats 1..8, in_valid=1, out_ready=1 → out_data 1..8 on consecutive cycles, count stays 1.
- Back-pressure, SKID=1: stream 1,2,3 with out_ready=0 from cycle 1 → count=2, in_ready=0, beat 3 held upstream. Release out_ready → outputs 1,2,3 in order with no loss or duplicate. Also check in_ready never depends combinationally on out_ready.
- Halt: count=1 holding 0x55, halted=1 for 3 cycles with out_ready=1 and in_valid=1 → out_valid=0, in_ready=0, count=1. After release, out 0x55 is delivered once.
- Flush: count=2, flush=1 together with halted=1 and in_valid=1 → next cycle count=0 and out_valid=0, and no flushed beat ever appears at the output.
- Async reset mid-stream: drop reset between clock edges while count=2 → out_valid=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - inter-stage payload types and widths for the pipeline registers
package pipe_pkg;

  // Fetch -> decode payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_t;

  // Decode -> execute payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_d;
    logic [31:0] rs2_d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } de_t;

  // Execute -> memory payload.
  typedef struct packed {
    logic [31:0] alu_y;
    logic [31:0] store_d;
    logic [4:0]  rd;
    logic        mem_we;
    logic        mem_re;
  } em_t;

  // Memory -> writeback payload.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] reg_d;
  } mw_t;

  localparam int FD_W = $bits(fd_t);
  localparam int DE_W = $bits(de_t);
  localparam int EM_W = $bits(em_t);
  localparam int MW_W = $bits(mw_t);

  // Occupancy of a two-entry buffer; the skid entry is only ever valid behind the main one.
  function automatic logic [1:0] entry_count(input logic v0, input logic v1);
    return {1'b0, v0} + {1'b0, v1};
  endfunction

endpackage

// File: rtl/flope.sv
// rtl/flope.sv - enable flop without reset, for payload storage
module flope #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load when enabled; contents are meaningless until a valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enable flop with asynchronous active-low reset
module flopenr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset, otherwise load when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid.sv
// rtl/pipe_skid.sv - two-entry skid buffer with registered in_ready
module pipe_skid import pipe_pkg::*; #(
  parameter int WIDTH = MW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halted,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             v0_q, v0_d, v0_en;
  logic             v1_q, v1_d, v1_en;
  logic [WIDTH-1:0] d0_q, d0_d, d1_q;
  logic             d0_en, d1_en;
  logic             in_fire, out_fire, skid_load;

  // in_ready comes only from the skid valid flop, so out_ready never reaches upstream combinationally.
  assign in_ready  = ~halted & ~v1_q;
  assign out_valid = v0_q & ~halted;
  assign out_data  = d0_q;
  assign count     = entry_count(v0_q, v1_q);

  // Next-state: main entry drains from skid first, new data parks in skid only while main is held.
  always_comb begin
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    skid_load = in_fire & v0_q & ~out_fire;

    v0_en = flush | in_fire | out_fire;
    v0_d  = ~flush & (out_fire ? (v1_q | in_fire) : 1'b1);

    v1_en = flush | skid_load | (out_fire & v1_q);
    v1_d  = ~flush & skid_load;

    d0_en = ~flush & ((out_fire & v1_q) | (in_fire & (out_fire | ~v0_q)));
    d0_d  = (out_fire & v1_q) ? d1_q : in_data;

    d1_en = ~flush & skid_load;
  end

  flopenr #(.W(1)) u_v0 (.clk(clk), .rst_n(reset), .en(v0_en), .d(v0_d), .q(v0_q));
  flopenr #(.W(1)) u_v1 (.clk(clk), .rst_n(reset), .en(v1_en), .d(v1_d), .q(v1_q));

  flope #(.W(WIDTH)) u_d0 (.clk(clk), .en(d0_en), .d(d0_d),    .q(d0_q));
  flope #(.W(WIDTH)) u_d1 (.clk(clk), .en(d1_en), .d(in_data), .q(d1_q));

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with handshake, flush and halt
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int WIDTH = MW_W,
  parameter int SKID  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halted,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] MAX_CNT = (SKID != 0) ? 2'd2 : 2'd1;

  logic in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    pipe_skid #(.WIDTH(WIDTH)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .halted    (halted),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
    );
  end else begin : g_single
    logic             v_q, v_d, v_en, d_en;
    logic [WIDTH-1:0] d_q;

    assign in_ready  = ~halted & (~v_q | out_ready);
    assign out_valid = v_q & ~halted;
    assign out_data  = d_q;
    assign count     = {1'b0, v_q};

    // Next-state: an incoming beat refills the entry, a lone outgoing beat empties it, flush kills it.
    always_comb begin
      v_en = flush | in_fire | out_fire;
      v_d  = ~flush & in_fire;
      d_en = ~flush & in_fire;
    end

    flopenr #(.W(1))     u_v (.clk(clk), .rst_n(reset), .en(v_en), .d(v_d),     .q(v_q));
    flope   #(.W(WIDTH)) u_d (.clk(clk), .en(d_en),                .d(in_data), .q(d_q));
  end

  // A held beat must not change under the consumer.
  a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !halted && !flush) |=> $stable(out_data));

  // Occupancy is bounded by the number of entries.
  a_count_max: assert property (@(posedge clk) disable iff (!reset)
    count <= MAX_CNT);

  // Accepting into a full stage without a simultaneous drain would lose data.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(in_fire && !out_fire && !flush && count == MAX_CNT));

endmodule
